// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath/register widths, ALU opcodes and
// the execute-stage FSM state encoding.
package proc_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } exec_state_t;

endpackage

// File: rtl/exec_mul_seq.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, DW cycles.
// start loads the operands; done is high in the cycle whose clock edge
// retires the last bit, with result already holding the final low-DW product.
module exec_mul_seq
  import proc_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          done,
  output logic [DW-1:0] result
);

  localparam int CW = $clog2(DW);

  logic          running_q, running_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0] mplier_q, mplier_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] acc_next;

  // Partial-product accumulation for the current multiplier bit
  always_comb begin
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    done     = running_q && (cnt_q == CW'(DW - 1));
    result   = acc_next;
  end

  // Next-state for the iteration registers
  always_comb begin
    running_d = running_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    if (start) begin
      running_d = 1'b1;
      cnt_d     = '0;
      mcand_d   = a;
      mplier_d  = b;
      acc_d     = '0;
    end else if (running_q) begin
      acc_d    = acc_next;
      mcand_d  = {mcand_q[DW-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[DW-1:1]};
      cnt_d    = cnt_q + 1'b1;
      if (done) running_d = 1'b0;
    end
  end

  // Iteration state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
    end else begin
      running_q <= running_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU ops with one register-file write per cycle,
// plus an optional 16-cycle sequential multiply.
// Build option: define EXEC_STAGE_MUL_EN to enable op 111 as MUL; otherwise
// op 111 is accepted as a NOP with no write.
module exec_stage
  import proc_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [REG_AW-1:0] dst,
  input  logic [DW-1:0]     a,
  input  logic [DW-1:0]     b,
  output logic [REG_AW-1:0] ws,
  output logic [DW-1:0]     wd,
  output logic              we,
  output logic              zero,
  output logic              neg,
  output logic              busy
);

  exec_state_t       state_q, state_d;
  logic [REG_AW-1:0] ws_q, ws_d;
  logic [DW-1:0]     wd_q, wd_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
  logic              accept;
  op_t               op_e;
  logic [DW-1:0]     alu_res;
  logic              mul_start;

`ifdef EXEC_STAGE_MUL_EN
  logic [REG_AW-1:0] mul_dst_q, mul_dst_d;
  logic              mul_done;
  logic [DW-1:0]     mul_result;

  exec_mul_seq #(.DW(DW)) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .result (mul_result)
  );
`endif

  // Single-cycle ALU result for the operation on the inputs
  always_comb begin
    op_e = op_t'(op);
    case (op_e)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SHL:  alu_res = a << b[3:0];
      OP_SHR:  alu_res = a >> b[3:0];
      default: alu_res = '0;
    endcase
  end

  // FSM and write-port next state; flags change only when a write completes
  always_comb begin
    accept    = in_valid && in_ready;
    state_d   = state_q;
    ws_d      = ws_q;
    wd_d      = wd_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    mul_start = 1'b0;
`ifdef EXEC_STAGE_MUL_EN
    mul_dst_d = mul_dst_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (op_e == OP_MUL) begin
`ifdef EXEC_STAGE_MUL_EN
            state_d   = ST_MUL;
            mul_start = 1'b1;
            mul_dst_d = dst;
`else
            state_d   = ST_IDLE;
`endif
          end else begin
            state_d = ST_DONE;
            ws_d    = dst;
            wd_d    = alu_res;
            zero_d  = (alu_res == '0);
            neg_d   = alu_res[DW-1];
          end
        end
      end
      ST_MUL: begin
`ifdef EXEC_STAGE_MUL_EN
        if (mul_done) begin
          state_d = ST_DONE;
          ws_d    = mul_dst_q;
          wd_d    = mul_result;
          zero_d  = (mul_result == '0);
          neg_d   = mul_result[DW-1];
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ws_q    <= '0;
      wd_q    <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ws_q    <= ws_d;
      wd_q    <= wd_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

`ifdef EXEC_STAGE_MUL_EN
  // Destination held across the multiply
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mul_dst_q <= '0;
    else       mul_dst_q <= mul_dst_d;
  end
`endif

  // Output decode
  always_comb begin
    in_ready = (state_q != ST_MUL);
    we       = (state_q == ST_DONE);
    ws       = ws_q;
    wd       = wd_q;
    zero     = zero_q;
    neg      = neg_q;
`ifdef EXEC_STAGE_MUL_EN
    busy     = (state_q == ST_MUL);
`else
    busy     = 1'b0;
`endif
  end

endmodule
